alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Instruction-side initiator for the combinational 16-bit ALU. It accepts 16-bit ALU instructions over a valid/ready handshake and decodes each one into alu_op, immCalc and operand values. It sources operands from an internal 8-entry register file, captures the ALU result Z, and writes it back. It sits between the instruction source (testbench or fetch stage) and the ALU, and owns the architectural register state for ALU operations.

Parameters:
DATA_W, 16, datapath and register width; must match ALU width
NREGS, 8, register file entries; r0 reads as zero
IMM_W, 6, immediate field width; zero-extended to DATA_W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
instr  input  16  instruction word
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  controller can accept an instruction (IDLE only)
alu_in1  output  DATA_W  ALU operand 1 (rs1 value)
alu_in2  output  DATA_W  ALU operand 2 (rs2 value)
alu_imm  output  DATA_W  zero-extended immediate
alu_op  output  3  ALU operation select
alu_imm_calc  output  1  ALU uses imm instead of in2
alu_z  input  DATA_W  ALU result
done  output  1  one-cycle pulse: instruction retired
err  output  1  one-cycle pulse, coincident with done: instruction faulted, no writeback
result  output  DATA_W  last retired value; held until next retire
dbg_addr  input  3  debug register read address
dbg_data  output  DATA_W  combinational read of reg[dbg_addr]

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Instruction encoding: [15:13] op; [12] immediate flag; [11:9] rd; [8:6] rs1; [5:3] rs2; [5:0] imm6.
- op 000..101 are passed straight to alu_op (add, sub, mul, div, shl, shr).
- op 110 = LI: rd <= zero-extended instr[8:0]; the ALU is not used.
- op 111 = illegal: err is set and there is no writeback.
- FSM states: IDLE, DECODE, EXEC, WB.
- IDLE: instr_ready=1. When instr_valid is high, latch instr and go to DECODE. When instr_valid is low, stay in IDLE.
- DECODE: register alu_op, alu_imm_calc, alu_in1=reg[rs1], alu_in2=reg[rs2] and alu_imm. Go to EXEC.
- EXEC: the ALU outputs are now stable. Capture alu_z into a result register. Go to WB.
- WB: write reg[rd], update result, pulse done. Go to IDLE.
- Latency: handshake at cycle 0 -> done at cycle 3. Peak throughput is one instruction per 4 cycles.
- instr_ready is low in DECODE, EXEC and WB. A valid asserted in those states is ignored, not queued.
- r0: reads always return 0. A write to rd=0 is discarded, but done still pulses and result still updates.
- Divide by zero (op 011, effective operand2 == 0): err pulses with done, there is no register write, and result is unchanged.
- Illegal op 111: err pulses with done, there is no register write, and result is unchanged.
- Arithmetic: all results are truncated to DATA_W bits, with no overflow flag. Shift amounts >= 16 yield 0 (ALU semantics).
- Debug port: dbg_data reflects the register array before the WB write edge. The new value is visible the cycle after done.
- Reset (any state, including mid-instruction):
  - FSM returns to IDLE and the in-flight instruction is dropped.
  - All registers and result are set to 0.
  - alu_op=000, alu_imm_calc=0, and alu_in1/in2/imm are set to 0.
  - done=0, err=0.
  - instr_ready=1 from the first cycle after reset deasserts.

Decomposition:
- Shared package alu_pkg holds:
  - op constants OP_ADD..OP_SHR, OP_LI, OP_ILL
  - instruction field bit positions
  - FSM state enum
  - DATA_W
- Natural sub-module: alu_regfile. It has NREGS x DATA_W storage, 2 combinational read ports plus a debug read port, 1 synchronous write port, synchronous reset, and an r0-zero rule.
- The controller FSM and decode logic stay in alu_issue_ctrl.

Test Plan:
- LI r1,0x005 then LI r2,0x003, then ADD r3,r1,r2 -> done 3 cycles after each handshake; result=0x0008; dbg_addr=3 reads 0x0008.
- SUB r4,r1,r2 then MUL r5,r1,r2 (r1=5, r2=3) -> results 0x0002 and 0x000F. SUB r6,r2,r1 -> 0xFFFE (wrap).
- ADD immediate, imm flag=1, r1=5, imm6=0x3F -> alu_imm_calc=1 during EXEC; result=0x0044.
- DIV r7,r1,r0 -> err and done pulse together; r7 unchanged; result keeps its prior value. Then op 111 -> err=1, no write.
- Hold instr_valid high continuously with distinct instrs -> exactly one is accepted per 4 cycles, and instr_ready=1 only in IDLE.
- Assert rst_n=0 in EXEC of an ADD to r3 -> no done; r3=0 after reset; instr_ready=1 the cycle after release; alu_op=000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: widths, opcodes,
// instruction field positions and the controller state encoding.
package alu_pkg;

  localparam int DATA_W  = 16;
  localparam int NREGS   = 8;
  localparam int IMM_W   = 6;
  localparam int INSTR_W = 16;
  localparam int REG_AW  = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_LI  = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 13;
  localparam int IMMF_BIT = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 9;
  localparam int RS1_MSB  = 8;
  localparam int RS1_LSB  = 6;
  localparam int RS2_MSB  = 5;
  localparam int RS2_LSB  = 3;
  localparam int IMM_MSB  = IMM_W - 1;
  localparam int LI_MSB   = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two operand read ports, a debug read port and
// one synchronous write port. Register 0 is hardwired to zero.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_data1 = (rd_addr1 == '0) ? '0 : regs_q[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : regs_q[rd_addr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the external 16-bit ALU: accepts one instruction at a
// time, drives registered ALU operands, and writes the result back.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  output logic [DATA_W-1:0]  alu_imm,
  output logic [2:0]         alu_op,
  output logic               alu_imm_calc,
  input  logic [DATA_W-1:0]  alu_z,
  output logic               done,
  output logic               err,
  output logic [DATA_W-1:0]  result,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               ready_q, ready_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic               imm_calc_q, imm_calc_d;
  logic [DATA_W-1:0]  in1_q, in1_d;
  logic [DATA_W-1:0]  in2_q, in2_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [DATA_W-1:0]  wb_val_q, wb_val_d;
  logic               wb_we_q, wb_we_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  result_q, result_d;

  logic [2:0]        op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [DATA_W-1:0] rs1_data, rs2_data, op2_eff;
  logic [DATA_W-1:0] exec_val;
  logic              exec_fault;

  assign op      = instr_q[OP_MSB:OP_LSB];
  assign rd      = instr_q[RD_MSB:RD_LSB];
  assign rs1     = instr_q[RS1_MSB:RS1_LSB];
  assign rs2     = instr_q[RS2_MSB:RS2_LSB];
  assign op2_eff = imm_calc_q ? imm_q : in2_q;

  alu_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr1 (rs1),
    .rd_addr2 (rs2),
    .dbg_addr (dbg_addr),
    .rd_data1 (rs1_data),
    .rd_data2 (rs2_data),
    .dbg_data (dbg_data),
    .we       (wb_we_q),
    .wr_addr  (rd),
    .wr_data  (wb_val_q)
  );

  // LI bypasses the ALU; illegal ops and divide-by-zero retire as faults.
  always_comb begin
    exec_val   = alu_z;
    exec_fault = 1'b0;
    case (op)
      OP_LI:   exec_val   = DATA_W'(instr_q[LI_MSB:0]);
      OP_ILL:  exec_fault = 1'b1;
      OP_DIV:  exec_fault = (op2_eff == '0);
      default: exec_val   = alu_z;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    ready_d    = ready_q;
    alu_op_d   = alu_op_q;
    imm_calc_d = imm_calc_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    imm_d      = imm_q;
    wb_val_d   = wb_val_q;
    wb_we_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          ready_d = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_op_d   = (op <= OP_SHR) ? op : OP_ADD;
        imm_calc_d = instr_q[IMMF_BIT];
        in1_d      = rs1_data;
        in2_d      = rs2_data;
        imm_d      = DATA_W'(instr_q[IMM_MSB:0]);
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        wb_val_d = exec_val;
        wb_we_d  = !exec_fault;
        done_d   = 1'b1;
        err_d    = exec_fault;
        if (!exec_fault) begin
          result_d = exec_val;
        end
        state_d = S_WB;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      ready_q    <= 1'b1;
      alu_op_q   <= OP_ADD;
      imm_calc_q <= 1'b0;
      in1_q      <= '0;
      in2_q      <= '0;
      imm_q      <= '0;
      wb_val_q   <= '0;
      wb_we_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      ready_q    <= ready_d;
      alu_op_q   <= alu_op_d;
      imm_calc_q <= imm_calc_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      imm_q      <= imm_d;
      wb_val_q   <= wb_val_d;
      wb_we_q    <= wb_we_d;
      done_q     <= done_d;
      err_q      <= err_d;
      result_q   <= result_d;
    end
  end

  assign instr_ready  = ready_q;
  assign alu_op       = alu_op_q;
  assign alu_imm_calc = imm_calc_q;
  assign alu_in1      = in1_q;
  assign alu_in2      = in2_q;
  assign alu_imm      = imm_q;
  assign done         = done_q;
  assign err          = err_q;
  assign result       = result_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: emulates the external ALU and checks
// retirement timing, results and register state against an instruction-level model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_in1, alu_in2, alu_imm, alu_z;
  logic [2:0]  alu_op;
  logic        alu_imm_calc;
  logic        done, err;
  logic [15:0] result;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int nchecks = 0;
  int nerrors = 0;

  logic [15:0] mreg [8];
  logic [15:0] mres;

  typedef struct {
    bit          timeout;
    logic        done1, ready1, immc1;
    logic [2:0]  op1;
    logic        done2, err2;
    logic [15:0] result2, dbg_old;
    logic        done3, ready3;
    logic [15:0] dbg_new;
  } obs_t;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_imm      (alu_imm),
    .alu_op       (alu_op),
    .alu_imm_calc (alu_imm_calc),
    .alu_z        (alu_z),
    .done         (done),
    .err          (err),
    .result       (result),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // Stand-in for the combinational ALU the controller drives
  always_comb begin
    logic [15:0] b;
    b = alu_imm_calc ? alu_imm : alu_in2;
    case (alu_op)
      3'd0:    alu_z = alu_in1 + b;
      3'd1:    alu_z = alu_in1 - b;
      3'd2:    alu_z = alu_in1 * b;
      3'd3:    alu_z = (b == 16'd0) ? 16'hFFFF : alu_in1 / b;
      3'd4:    alu_z = (b >= 16'd16) ? 16'd0 : alu_in1 << b;
      3'd5:    alu_z = (b >= 16'd16) ? 16'd0 : alu_in1 >> b;
      default: alu_z = 16'h0BAD;
    endcase
  end

  function automatic logic [15:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
    logic [15:0] w;
    w = {op[2:0], 1'b0, rd[2:0], rs1[2:0], rs2[2:0], 3'b000};
    return w;
  endfunction

  function automatic logic [15:0] enc_i(input int op, input int rd, input int rs1, input int imm);
    logic [15:0] w;
    w = {op[2:0], 1'b1, rd[2:0], rs1[2:0], imm[5:0]};
    return w;
  endfunction

  function automatic logic [15:0] enc_li(input int rd, input int val);
    logic [15:0] w;
    w = {3'b110, 1'b0, rd[2:0], val[8:0]};
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = 16'd0;
    mres = 16'd0;
  endtask

  // Instruction-level reference: computes the retired value and updates state
  task automatic ref_exec(input logic [15:0] w, output logic [15:0] val, output bit fault);
    int unsigned a, b, op, rd;
    op    = w[15:13];
    rd    = w[11:9];
    a     = mreg[w[8:6]];
    b     = w[12] ? int'(w[5:0]) : int'(mreg[w[5:3]]);
    fault = 1'b0;
    val   = 16'd0;
    case (op)
      0: val = 16'((a + b) % 65536);
      1: val = 16'((a + 65536 - b) % 65536);
      2: val = 16'((a * b) % 65536);
      3: if (b == 0) fault = 1'b1; else val = 16'(a / b);
      4: val = (b >= 16) ? 16'd0 : 16'((a * (1 << b)) % 65536);
      5: val = (b >= 16) ? 16'd0 : 16'(a / (1 << b));
      6: val = 16'(w[8:0]);
      default: fault = 1'b1;
    endcase
    if (!fault) begin
      mres = val;
      if (rd != 0) mreg[rd] = val;
    end
  endtask

  task automatic issue(input logic [15:0] w, output obs_t o);
    int waitc = 0;
    @(negedge clk);
    while (!instr_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    o.timeout = !instr_ready;
    dbg_addr = w[11:9];
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    @(posedge clk); #1;
    o.done1 = done; o.ready1 = instr_ready; o.immc1 = alu_imm_calc; o.op1 = alu_op;
    @(posedge clk); #1;
    o.done2 = done; o.err2 = err; o.result2 = result; o.dbg_old = dbg_data;
    @(posedge clk); #1;
    o.done3 = done; o.ready3 = instr_ready; o.dbg_new = dbg_data;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset(3);
    #1;
    nchecks++;
    if (instr_ready !== 1'b1) begin nerrors++; $display("[TB] FAIL reset_ready got %0b want 1", instr_ready); end
    nchecks++;
    if ({done, err} !== 2'b00) begin nerrors++; $display("[TB] FAIL reset_done_err got %b want 00", {done, err}); end
    nchecks++;
    if (result !== 16'h0000) begin nerrors++; $display("[TB] FAIL reset_result got %h want 0000", result); end
    nchecks++;
    if ({alu_op, alu_imm_calc, alu_in1, alu_in2, alu_imm} !== '0) begin
      nerrors++; $display("[TB] FAIL reset_alu_outs op %0d immc %0b in1 %h in2 %h imm %h want all 0",
                          alu_op, alu_imm_calc, alu_in1, alu_in2, alu_imm);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      nchecks++;
      if (dbg_data !== 16'h0000) begin nerrors++; $display("[TB] FAIL reset_reg r%0d got %h want 0000", i, dbg_data); end
    end
  endtask

  task automatic test_directed();
    logic [15:0] prog [13];
    logic [15:0] want_res [13];
    obs_t o;
    logic [15:0] val, old_rd;
    bit fault;
    prog[0]  = enc_li(1, 5);          want_res[0]  = 16'h0005;
    prog[1]  = enc_li(2, 3);          want_res[1]  = 16'h0003;
    prog[2]  = enc_r(0, 3, 1, 2);     want_res[2]  = 16'h0008;
    prog[3]  = enc_r(1, 4, 1, 2);     want_res[3]  = 16'h0002;
    prog[4]  = enc_r(2, 5, 1, 2);     want_res[4]  = 16'h000F;
    prog[5]  = enc_r(1, 6, 2, 1);     want_res[5]  = 16'hFFFE;
    prog[6]  = enc_i(0, 6, 1, 63);    want_res[6]  = 16'h0044;
    prog[7]  = enc_r(3, 7, 1, 0);     want_res[7]  = 16'h0044;
    prog[8]  = enc_r(7, 1, 2, 3);     want_res[8]  = 16'h0044;
    prog[9]  = enc_li(0, 9'h1AB);     want_res[9]  = 16'h01AB;
    prog[10] = enc_i(4, 2, 1, 16);    want_res[10] = 16'h0000;
    prog[11] = enc_i(5, 3, 4, 1);     want_res[11] = 16'h0001;
    prog[12] = enc_i(3, 4, 5, 4);     want_res[12] = 16'h0003;
    for (int k = 0; k < 13; k++) begin
      old_rd = mreg[prog[k][11:9]];
      ref_exec(prog[k], val, fault);
      issue(prog[k], o);
      nchecks++;
      if (o.timeout) begin nerrors++; $display("[TB] FAIL dir%0d_ready_timeout got 0 want 1", k); end
      nchecks++;
      if (o.done1 !== 1'b0 || o.ready1 !== 1'b0) begin
        nerrors++; $display("[TB] FAIL dir%0d_exec_flags done %b ready %b want 0 0", k, o.done1, o.ready1);
      end
      if (prog[k][15:13] <= 3'd5) begin
        nchecks++;
        if (o.immc1 !== prog[k][12] || o.op1 !== prog[k][15:13]) begin
          nerrors++; $display("[TB] FAIL dir%0d_alu_ctrl immc %b op %0d want %b %0d",
                              k, o.immc1, o.op1, prog[k][12], prog[k][15:13]);
        end
      end
      nchecks++;
      if (o.done2 !== 1'b1 || o.err2 !== fault) begin
        nerrors++; $display("[TB] FAIL dir%0d_done_err got %b%b want 1%b", k, o.done2, o.err2, fault);
      end
      nchecks++;
      if (o.result2 !== mres || mres !== want_res[k]) begin
        nerrors++; $display("[TB] FAIL dir%0d_result got %h model %h want %h", k, o.result2, mres, want_res[k]);
      end
      nchecks++;
      if (o.dbg_old !== old_rd || o.dbg_new !== mreg[prog[k][11:9]]) begin
        nerrors++; $display("[TB] FAIL dir%0d_regwrite old %h new %h want %h %h",
                            k, o.dbg_old, o.dbg_new, old_rd, mreg[prog[k][11:9]]);
      end
      nchecks++;
      if (o.done3 !== 1'b0 || o.ready3 !== 1'b1) begin
        nerrors++; $display("[TB] FAIL dir%0d_retire done %b ready %b want 0 1", k, o.done3, o.ready3);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [15:0] w, val, old_rd;
    bit fault;
    for (int k = 0; k < 40; k++) begin
      w = 16'($urandom);
      if (k % 5 == 0) w[15:13] = 3'b110;
      old_rd = mreg[w[11:9]];
      ref_exec(w, val, fault);
      issue(w, o);
      nchecks++;
      if (o.timeout || o.done1 !== 1'b0 || o.done2 !== 1'b1 || o.done3 !== 1'b0) begin
        nerrors++; $display("[TB] FAIL rnd%0d_done_timing instr %h got %b%b%b want 010", k, w, o.done1, o.done2, o.done3);
      end
      nchecks++;
      if (o.err2 !== fault || o.result2 !== mres) begin
        nerrors++; $display("[TB] FAIL rnd%0d_result instr %h err %b res %h want %b %h", k, w, o.err2, o.result2, fault, mres);
      end
      nchecks++;
      if (o.dbg_old !== old_rd || o.dbg_new !== mreg[w[11:9]]) begin
        nerrors++; $display("[TB] FAIL rnd%0d_regwrite instr %h old %h new %h want %h %h",
                            k, w, o.dbg_old, o.dbg_new, old_rd, mreg[w[11:9]]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] acc [$];
    logic [15:0] w, val;
    bit fault;
    int last_acc = -1;
    int n_acc = 0, n_done = 0;
    @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      if (done) begin
        n_done++;
        nchecks++;
        if (acc.size() == 0) begin
          nerrors++; $display("[TB] FAIL b2b_spurious_done cycle %0d got 1 want 0", c);
        end else begin
          w = acc.pop_front();
          ref_exec(w, val, fault);
          if (err !== fault || result !== mres) begin
            nerrors++; $display("[TB] FAIL b2b_result instr %h err %b res %h want %b %h", w, err, result, fault, mres);
          end
        end
      end
      if (c < 48) begin
        w = 16'($urandom);
        w[15:13] = 3'($urandom_range(0, 6));
        instr = w;
        instr_valid = 1'b1;
        #1;
        if (instr_ready) begin
          nchecks++;
          if (last_acc >= 0 && c - last_acc != 4) begin
            nerrors++; $display("[TB] FAIL b2b_accept_gap got %0d want 4", c - last_acc);
          end
          last_acc = c;
          acc.push_back(w);
          n_acc++;
        end
      end else begin
        instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    nchecks++;
    if (n_acc != 12 || n_done != n_acc) begin
      nerrors++; $display("[TB] FAIL b2b_counts accepted %0d retired %0d want 12 12", n_acc, n_done);
    end
  endtask

  task automatic test_mid_reset();
    int seen_done = 0;
    @(negedge clk);
    instr = enc_r(0, 3, 1, 2);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    seen_done += int'(done);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    dbg_addr = 3'd3;
    #1;
    nchecks++;
    if (instr_ready !== 1'b1 || alu_op !== 3'b000) begin
      nerrors++; $display("[TB] FAIL midrst_ready_op ready %b op %0d want 1 0", instr_ready, alu_op);
    end
    nchecks++;
    if (dbg_data !== 16'h0000 || result !== 16'h0000) begin
      nerrors++; $display("[TB] FAIL midrst_state r3 %h result %h want 0000 0000", dbg_data, result);
    end
    repeat (5) begin
      @(posedge clk); #1;
      seen_done += int'(done);
    end
    nchecks++;
    if (seen_done != 0) begin
      nerrors++; $display("[TB] FAIL midrst_no_done got %0d pulses want 0", seen_done);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    instr = 16'h0000;
    instr_valid = 1'b0;
    dbg_addr = 3'd0;
    model_reset();
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
